// File: rtl/accum_bank.sv
// Banked signed accumulator table: NUM_COLS lanes per row, masked accumulate/overwrite,
// optional saturation with sticky per-lane overflow, and a row-per-cycle table clear.
module accum_bank #(
    parameter int DATA_WIDTH   = 8,
    parameter int ACC_WIDTH    = 16,
    parameter int NUM_COLS     = 16,
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SATURATE     = 1,
    localparam int DEPTH = MAX_OUT_ROWS * (MAX_OUT_COLS / NUM_COLS),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    output logic                           busy,
    input  logic                           wr_en,
    input  logic                           wr_mode,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [NUM_COLS-1:0]            wr_mask,
    input  logic [NUM_COLS*DATA_WIDTH-1:0] wr_data,
    input  logic                           rd_en,
    input  logic [AW-1:0]                  rd_addr,
    output logic [NUM_COLS*ACC_WIDTH-1:0]  rd_data,
    output logic                           rd_valid,
    output logic [NUM_COLS-1:0]            ovf_sticky
);

    localparam int ROW_W = NUM_COLS * ACC_WIDTH;
    localparam logic [AW:0]          DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0]        LAST_ROW = AW'(DEPTH - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH - 1){1'b0}}};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       clr_ptr_q, clr_ptr_d;
    logic [ROW_W-1:0]    mem_q [DEPTH];
    logic [ROW_W-1:0]    rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic [NUM_COLS-1:0] ovf_q, ovf_d;

    logic                idle;
    logic                clear_start;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                wr_fire;
    logic                rd_fire;
    logic [ROW_W-1:0]    wr_row;
    logic [ROW_W-1:0]    row_upd;
    logic [NUM_COLS-1:0] lane_ovf;

    assign idle        = (state_q == S_IDLE);
    assign clear_start = idle & clear;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_W);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_W);
    assign wr_fire     = idle & ~clear & wr_en & wr_in_range;
    assign rd_fire     = idle & ~clear & rd_en;
    assign wr_row      = mem_q[wr_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clear) begin
                    state_d   = S_CLEAR;
                    clr_ptr_d = '0;
                end
            end
            S_CLEAR: begin
                if (clr_ptr_q == LAST_ROW) begin
                    state_d   = S_IDLE;
                    clr_ptr_d = '0;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == S_CLEAR);
    end

    // Per-lane read-modify-write: sum is formed one bit wider so overflow is exact.
    for (genvar g = 0; g < NUM_COLS; g++) begin : g_lane
        logic [ACC_WIDTH-1:0] old_v;
        logic [ACC_WIDTH:0]   ext_v;
        logic [ACC_WIDTH:0]   sum_v;
        logic                 ovf_v;
        logic [ACC_WIDTH-1:0] new_v;

        assign old_v = wr_row[g*ACC_WIDTH +: ACC_WIDTH];
        assign ext_v = {{(ACC_WIDTH + 1 - DATA_WIDTH){wr_data[g*DATA_WIDTH + DATA_WIDTH - 1]}},
                        wr_data[g*DATA_WIDTH +: DATA_WIDTH]};
        assign sum_v = {old_v[ACC_WIDTH-1], old_v} + ext_v;
        assign ovf_v = (sum_v[ACC_WIDTH] != sum_v[ACC_WIDTH-1]);

        always_comb begin
            new_v = sum_v[ACC_WIDTH-1:0];
            if (wr_mode) begin
                new_v = ext_v[ACC_WIDTH-1:0];
            end else if (ovf_v && (SATURATE != 0)) begin
                new_v = sum_v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            end
        end

        assign row_upd[g*ACC_WIDTH +: ACC_WIDTH] = wr_mask[g] ? new_v : old_v;
        assign lane_ovf[g] = wr_mask[g] & ~wr_mode & ovf_v;
    end

    always_comb begin
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        if (clear_start) begin
            ovf_d = '0;
        end else if (wr_fire) begin
            ovf_d = ovf_q | lane_ovf;
        end
        if (rd_fire) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in_range ? mem_q[rd_addr] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= '0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ovf_q      <= ovf_d;
        end
    end

    // The table itself has no reset; the clear sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == S_CLEAR) begin
                mem_q[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                mem_q[wr_addr] <= row_upd;
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: a saturating and a wrapping instance share stimulus and are
// compared against an integer model of the accumulator table.
module tb_accum_bank;

    localparam int DW      = 8;
    localparam int ACC     = 10;
    localparam int NC      = 2;
    localparam int DEPTH   = 8;
    localparam int ACC_MAX = 511;
    localparam int ACC_MIN = -512;

    logic           clk = 1'b0;
    logic           reset;
    logic           clear;
    logic           wr_en;
    logic           wr_mode;
    logic [2:0]     wr_addr;
    logic [NC-1:0]  wr_mask;
    logic [15:0]    wr_data;
    logic           rd_en;
    logic [2:0]     rd_addr;

    logic           busy_sat, busy_wrap;
    logic [19:0]    rd_data_sat, rd_data_wrap;
    logic           rd_valid_sat, rd_valid_wrap;
    logic [NC-1:0]  ovf_sat, ovf_wrap;

    int             m_sat  [DEPTH][NC];
    int             m_wrap [DEPTH][NC];
    logic [NC-1:0]  eo_sat, eo_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    accum_bank #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC),
        .MAX_OUT_ROWS(4), .MAX_OUT_COLS(4), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_sat),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_sat), .rd_valid(rd_valid_sat), .ovf_sticky(ovf_sat)
    );

    accum_bank #(
        .DATA_WIDTH(DW), .ACC_WIDTH(ACC), .NUM_COLS(NC),
        .MAX_OUT_ROWS(4), .MAX_OUT_COLS(4), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy_wrap),
        .wr_en(wr_en), .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_wrap), .rd_valid(rd_valid_wrap), .ovf_sticky(ovf_wrap)
    );

    function automatic integer lane_val(input logic [19:0] bus, input int lane);
        logic [ACC-1:0] raw;
        raw = bus[lane*ACC +: ACC];
        return integer'($signed(raw));
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            for (int l = 0; l < NC; l++) begin
                m_sat[r][l]  = 0;
                m_wrap[r][l] = 0;
            end
        end
        eo_sat  = '0;
        eo_wrap = '0;
    endtask

    task automatic model_write(input int addr, input bit mode, input logic [NC-1:0] mask,
                               input int d0, input int d1);
        int d;
        int sum;
        for (int l = 0; l < NC; l++) begin
            if (mask[l]) begin
                d = (l == 0) ? d0 : d1;
                if (mode) begin
                    m_sat[addr][l]  = d;
                    m_wrap[addr][l] = d;
                end else begin
                    sum = m_sat[addr][l] + d;
                    if (sum > ACC_MAX) begin
                        m_sat[addr][l] = ACC_MAX;
                        eo_sat[l] = 1'b1;
                    end else if (sum < ACC_MIN) begin
                        m_sat[addr][l] = ACC_MIN;
                        eo_sat[l] = 1'b1;
                    end else begin
                        m_sat[addr][l] = sum;
                    end
                    sum = m_wrap[addr][l] + d;
                    if (sum > ACC_MAX) begin
                        m_wrap[addr][l] = sum - 1024;
                        eo_wrap[l] = 1'b1;
                    end else if (sum < ACC_MIN) begin
                        m_wrap[addr][l] = sum + 1024;
                        eo_wrap[l] = 1'b1;
                    end else begin
                        m_wrap[addr][l] = sum;
                    end
                end
            end
        end
    endtask

    task automatic drive_write(input int addr, input bit mode, input logic [NC-1:0] mask,
                               input int d0, input int d1);
        logic [7:0] b0;
        logic [7:0] b1;
        b0 = d0[7:0];
        b1 = d1[7:0];
        wr_en   = 1'b1;
        wr_mode = mode;
        wr_addr = 3'(addr);
        wr_mask = mask;
        wr_data = {b1, b0};
    endtask

    task automatic do_write(input int addr, input bit mode, input logic [NC-1:0] mask,
                            input int d0, input int d1);
        drive_write(addr, mode, mask, d0, d1);
        cycle();
        wr_en = 1'b0;
        model_write(addr, mode, mask, d0, d1);
    endtask

    task automatic do_read(input int addr);
        rd_en   = 1'b1;
        rd_addr = 3'(addr);
        cycle();
        rd_en = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int cnt;
        cnt = 0;
        while (busy_sat === 1'b1 && cnt < 20) begin
            cycle();
            cnt++;
        end
        n_checks++;
        if (cnt != DEPTH || busy_wrap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL %s: busy cycles %0d (wrap busy now %b), expected %0d then 0",
                     name, cnt, busy_wrap, DEPTH);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        n_checks++;
        if (busy_sat !== 1'b1 || rd_valid_sat !== 1'b0 || rd_data_sat !== 20'd0 || ovf_sat !== 2'b00 ||
            busy_wrap !== 1'b1 || rd_valid_wrap !== 1'b0 || rd_data_wrap !== 20'd0 || ovf_wrap !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_state: busy %b/%b valid %b/%b data %h/%h ovf %b/%b, expected 1 0 0 00",
                     busy_sat, busy_wrap, rd_valid_sat, rd_valid_wrap, rd_data_sat, rd_data_wrap,
                     ovf_sat, ovf_wrap);
        end
        count_busy("reset_busy_len");
        model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            do_read(r);
            n_checks++;
            if (rd_valid_sat !== 1'b1 || rd_valid_wrap !== 1'b1 ||
                lane_val(rd_data_sat, 0) !== 0 || lane_val(rd_data_sat, 1) !== 0 ||
                lane_val(rd_data_wrap, 0) !== 0 || lane_val(rd_data_wrap, 1) !== 0) begin
                n_fail++;
                $display("[TB] FAIL reset_read row %0d: valid %b/%b data %h/%h, expected valid 1 data 0",
                         r, rd_valid_sat, rd_valid_wrap, rd_data_sat, rd_data_wrap);
            end
        end
        cycle();
        n_checks++;
        if (rd_valid_sat !== 1'b0 || rd_valid_wrap !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL read_valid_drop: valid %b/%b, expected 0", rd_valid_sat, rd_valid_wrap);
        end
    endtask

    task automatic test_mask_accum();
        for (int i = 0; i < 3; i++) begin
            drive_write(3, 1'b0, 2'b01, 5, 9);
            cycle();
            model_write(3, 1'b0, 2'b01, 5, 9);
        end
        wr_en = 1'b0;
        do_read(3);
        n_checks++;
        if (lane_val(rd_data_sat, 0) !== 15 || lane_val(rd_data_sat, 1) !== 0 ||
            lane_val(rd_data_wrap, 0) !== m_wrap[3][0] || lane_val(rd_data_wrap, 1) !== m_wrap[3][1]) begin
            n_fail++;
            $display("[TB] FAIL mask_accum: sat %0d,%0d wrap %0d,%0d, expected 15,0",
                     lane_val(rd_data_sat, 0), lane_val(rd_data_sat, 1),
                     lane_val(rd_data_wrap, 0), lane_val(rd_data_wrap, 1));
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) do_write(1, 1'b0, 2'b01, 127, 0);
        do_read(1);
        n_checks++;
        if (lane_val(rd_data_sat, 0) !== 511 || lane_val(rd_data_wrap, 0) !== -389) begin
            n_fail++;
            $display("[TB] FAIL pos_overflow: sat %0d wrap %0d, expected 511 and -389",
                     lane_val(rd_data_sat, 0), lane_val(rd_data_wrap, 0));
        end
        n_checks++;
        if (ovf_sat !== 2'b01 || ovf_wrap !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL ovf_set: sat %b wrap %b, expected 01", ovf_sat, ovf_wrap);
        end
        for (int i = 0; i < 5; i++) do_write(2, 1'b0, 2'b01, -128, 0);
        do_read(2);
        n_checks++;
        if (lane_val(rd_data_sat, 0) !== -512 || lane_val(rd_data_wrap, 0) !== m_wrap[2][0]) begin
            n_fail++;
            $display("[TB] FAIL neg_overflow: sat %0d wrap %0d, expected -512 and %0d",
                     lane_val(rd_data_sat, 0), lane_val(rd_data_wrap, 0), m_wrap[2][0]);
        end
    endtask

    task automatic test_overwrite();
        do_write(3, 1'b1, 2'b01, -7, 0);
        do_read(3);
        n_checks++;
        if (rd_data_sat[9:0] !== 10'h3F9 || rd_data_wrap[9:0] !== 10'h3F9 ||
            lane_val(rd_data_sat, 1) !== m_sat[3][1]) begin
            n_fail++;
            $display("[TB] FAIL overwrite: lane0 %h/%h lane1 %0d, expected 3f9 and %0d",
                     rd_data_sat[9:0], rd_data_wrap[9:0], lane_val(rd_data_sat, 1), m_sat[3][1]);
        end
        n_checks++;
        if (ovf_sat !== eo_sat || ovf_wrap !== eo_wrap) begin
            n_fail++;
            $display("[TB] FAIL overwrite_ovf: %b/%b, expected %b/%b", ovf_sat, ovf_wrap, eo_sat, eo_wrap);
        end
    endtask

    task automatic test_same_cycle();
        do_write(5, 1'b1, 2'b01, 6, 0);
        drive_write(5, 1'b0, 2'b01, 4, 0);
        rd_en   = 1'b1;
        rd_addr = 3'd5;
        cycle();
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_write(5, 1'b0, 2'b01, 4, 0);
        n_checks++;
        if (rd_valid_sat !== 1'b1 || lane_val(rd_data_sat, 0) !== 6 || lane_val(rd_data_wrap, 0) !== 6) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_rd: valid %b data %0d/%0d, expected 1 and 6",
                     rd_valid_sat, lane_val(rd_data_sat, 0), lane_val(rd_data_wrap, 0));
        end
        do_read(5);
        n_checks++;
        if (lane_val(rd_data_sat, 0) !== 10 || lane_val(rd_data_wrap, 0) !== 10) begin
            n_fail++;
            $display("[TB] FAIL same_cycle_after: %0d/%0d, expected 10",
                     lane_val(rd_data_sat, 0), lane_val(rd_data_wrap, 0));
        end
    endtask

    task automatic test_back_to_back();
        integer hs [NC];
        integer hw [NC];
        logic   ev;
        for (int it = 0; it < 80; it++) begin
            bit            we;
            bit            md;
            bit            re;
            logic [NC-1:0] mk;
            int            wa;
            int            ra;
            int            d0;
            int            d1;
            we = 1'($urandom_range(0, 1));
            md = ($urandom_range(0, 3) == 0);
            mk = 2'($urandom_range(0, 3));
            wa = int'($urandom_range(0, 7));
            d0 = int'($urandom_range(0, 255)) - 128;
            d1 = int'($urandom_range(0, 255)) - 128;
            re = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ra = int'($urandom_range(0, 7));
            drive_write(wa, md, mk, d0, d1);
            wr_en   = we;
            rd_en   = re;
            rd_addr = 3'(ra);
            ev = re;
            if (re) begin
                for (int l = 0; l < NC; l++) begin
                    hs[l] = m_sat[ra][l];
                    hw[l] = m_wrap[ra][l];
                end
            end
            cycle();
            if (we) model_write(wa, md, mk, d0, d1);
            n_checks++;
            if (rd_valid_sat !== ev || rd_valid_wrap !== ev ||
                lane_val(rd_data_sat, 0) !== hs[0] || lane_val(rd_data_sat, 1) !== hs[1] ||
                lane_val(rd_data_wrap, 0) !== hw[0] || lane_val(rd_data_wrap, 1) !== hw[1]) begin
                n_fail++;
                $display("[TB] FAIL random_read it %0d: valid %b/%b sat %0d,%0d wrap %0d,%0d, expected %b sat %0d,%0d wrap %0d,%0d",
                         it, rd_valid_sat, rd_valid_wrap,
                         lane_val(rd_data_sat, 0), lane_val(rd_data_sat, 1),
                         lane_val(rd_data_wrap, 0), lane_val(rd_data_wrap, 1),
                         ev, hs[0], hs[1], hw[0], hw[1]);
            end
            n_checks++;
            if (ovf_sat !== eo_sat || ovf_wrap !== eo_wrap) begin
                n_fail++;
                $display("[TB] FAIL random_ovf it %0d: %b/%b, expected %b/%b",
                         it, ovf_sat, ovf_wrap, eo_sat, eo_wrap);
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic test_clear();
        integer held;
        do_write(4, 1'b1, 2'b11, 33, -20);
        do_read(4);
        held = m_sat[4][0];
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        n_checks++;
        if (busy_sat !== 1'b1 || ovf_sat !== 2'b00 || ovf_wrap !== 2'b00 || rd_valid_sat !== 1'b0 ||
            lane_val(rd_data_sat, 0) !== held) begin
            n_fail++;
            $display("[TB] FAIL clear_start: busy %b ovf %b/%b valid %b data %0d, expected 1 00 0 %0d",
                     busy_sat, ovf_sat, ovf_wrap, rd_valid_sat, lane_val(rd_data_sat, 0), held);
        end
        for (int r = 0; r < DEPTH; r++) begin
            drive_write(r, 1'b0, 2'b11, 1, 1);
            rd_en   = 1'b1;
            rd_addr = 3'(r);
            cycle();
            n_checks++;
            if (rd_valid_sat !== 1'b0 || rd_valid_wrap !== 1'b0 || busy_sat !== (r < DEPTH - 1)) begin
                n_fail++;
                $display("[TB] FAIL clear_busy cycle %0d: valid %b/%b busy %b, expected 0 and busy %b",
                         r, rd_valid_sat, rd_valid_wrap, busy_sat, (r < DEPTH - 1));
            end
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_clear();
        for (int r = 0; r < DEPTH; r++) begin
            do_read(r);
            n_checks++;
            if (rd_valid_sat !== 1'b1 || rd_data_sat !== 20'd0 || rd_data_wrap !== 20'd0 ||
                ovf_sat !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL clear_read row %0d: valid %b data %h/%h ovf %b, expected 1 0 0 00",
                         r, rd_valid_sat, rd_data_sat, rd_data_wrap, ovf_sat);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        n_checks++;
        if (busy_sat !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL mid_clear_busy: %b, expected 1", busy_sat);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        count_busy("mid_clear_reset_len");
        model_clear();
        do_write(0, 1'b0, 2'b11, 3, -3);
        do_read(0);
        n_checks++;
        if (lane_val(rd_data_sat, 0) !== 3 || lane_val(rd_data_sat, 1) !== -3 ||
            lane_val(rd_data_wrap, 0) !== 3 || lane_val(rd_data_wrap, 1) !== -3) begin
            n_fail++;
            $display("[TB] FAIL post_reset_write: sat %0d,%0d wrap %0d,%0d, expected 3,-3",
                     lane_val(rd_data_sat, 0), lane_val(rd_data_sat, 1),
                     lane_val(rd_data_wrap, 0), lane_val(rd_data_wrap, 1));
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        clear   = 1'b0;
        wr_en   = 1'b0;
        wr_mode = 1'b0;
        wr_addr = '0;
        wr_mask = '0;
        wr_data = '0;
        rd_en   = 1'b0;
        rd_addr = '0;
        model_clear();
        test_reset();
        test_mask_accum();
        test_saturate();
        test_overwrite();
        test_same_cycle();
        test_back_to_back();
        test_clear();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
